// File: rtl/mul_fu_if.sv
// Issue-side and CDB-side handshake bundle for the multiply unit.
// master = issue/arbiter side, slave = functional unit.
interface mul_fu_if #(
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [TAG_W-1:0] in_tag;
  logic [15:0]      in_a;
  logic [15:0]      in_b;
  logic             flush;
  logic             cdb_req;
  logic             cdb_grant;
  logic [TAG_W-1:0] cdb_tag;
  logic [31:0]      cdb_data;
  logic [2:0]       occ;

  modport master (
    output in_valid, in_tag, in_a, in_b,
    output flush, cdb_grant,
    input  in_ready, cdb_req, cdb_tag,
    input  cdb_data, occ
  );

  modport slave (
    input  in_valid, in_tag, in_a, in_b,
    input  flush, cdb_grant,
    output in_ready, cdb_req, cdb_tag,
    output cdb_data, occ
  );
endinterface

// File: rtl/mul_fu.sv
// Pipelined 16x16 unsigned multiply unit: S1 operand regs, Wallace
// tree into S2, then a 2-entry result queue arbitrating for the CDB.
module mul_fu #(
  parameter int TAG_W = 4,
  parameter int DEPTH = 4
) (
  input logic     clk,
  input logic     rst,
  mul_fu_if.slave bus
);

  logic             s1_v_q, s1_v_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
  logic [15:0]      s1_a_q, s1_a_d;
  logic [15:0]      s1_b_q, s1_b_d;

  logic             s2_v_q, s2_v_d;
  logic [TAG_W-1:0] s2_tag_q, s2_tag_d;
  logic [31:0]      s2_p_q, s2_p_d;

  logic [1:0]       q_cnt_q, q_cnt_d;
  logic [TAG_W-1:0] q_tag_q [2];
  logic [TAG_W-1:0] q_tag_d [2];
  logic [31:0]      q_dat_q [2];
  logic [31:0]      q_dat_d [2];

  logic [2:0]       occ_q, occ_d;

  logic             acc, pop, s2_adv, s1_adv;
  logic [1:0]       q_base;
  logic [31:0]      prod;

  logic [31:0]      row [16];
  logic [31:0]      nxt [16];
  logic [3:0]       m;
  int               n;

  assign bus.in_ready = occ_q < 3'(DEPTH);
  assign bus.cdb_req  = q_cnt_q != 2'd0;
  assign bus.cdb_tag  = q_tag_q[0];
  assign bus.cdb_data = q_dat_q[0];
  assign bus.occ      = occ_q;

  assign acc    = bus.in_valid && bus.in_ready;
  assign pop    = bus.cdb_req && bus.cdb_grant;
  assign s2_adv = s2_v_q && (q_cnt_q != 2'd2 || pop);
  assign s1_adv = s1_v_q && (!s2_v_q || s2_adv);

  // Carry-save 3:2 reduction of the partial products down to two rows.
  always_comb begin
    for (int i = 0; i < 16; i++)
      row[i] = s1_b_q[i] ? (32'(s1_a_q) << i) : 32'd0;
    n = 16;
    for (int l = 0; l < 6; l++) begin
      for (int i = 0; i < 16; i++)
        nxt[i] = '0;
      m = '0;
      for (int j = 0; j < 5; j++) begin
        if (3*j+2 < n) begin
          nxt[m] = row[3*j] ^ row[3*j+1] ^ row[3*j+2];
          nxt[m+4'd1] = ((row[3*j] & row[3*j+1]) |
                         (row[3*j] & row[3*j+2]) |
                         (row[3*j+1] & row[3*j+2])) << 1;
          m = m + 4'd2;
        end
      end
      for (int i = 0; i < 16; i++) begin
        if (i >= 3*(n/3) && i < n) begin
          nxt[m] = row[i];
          m = m + 4'd1;
        end
      end
      row = nxt;
      n = int'(m);
    end
    prod = row[0] + row[1];
  end

  always_comb begin
    s1_v_d   = s1_v_q;
    s1_tag_d = s1_tag_q;
    s1_a_d   = s1_a_q;
    s1_b_d   = s1_b_q;
    if (acc) begin
      s1_v_d   = 1'b1;
      s1_tag_d = bus.in_tag;
      s1_a_d   = bus.in_a;
      s1_b_d   = bus.in_b;
    end else if (s1_adv) begin
      s1_v_d = 1'b0;
    end

    s2_v_d   = s2_v_q;
    s2_tag_d = s2_tag_q;
    s2_p_d   = s2_p_q;
    if (s1_adv) begin
      s2_v_d   = 1'b1;
      s2_tag_d = s1_tag_q;
      s2_p_d   = prod;
    end else if (s2_adv) begin
      s2_v_d = 1'b0;
    end

    q_tag_d = q_tag_q;
    q_dat_d = q_dat_q;
    q_base  = q_cnt_q - {1'b0, pop};
    if (pop) begin
      q_tag_d[0] = q_tag_q[1];
      q_dat_d[0] = q_dat_q[1];
    end
    // A push always lands in slot 0 or 1 after any pop has shifted.
    if (s2_adv) begin
      q_tag_d[q_base[0]] = s2_tag_q;
      q_dat_d[q_base[0]] = s2_p_q;
    end
    q_cnt_d = q_base + {1'b0, s2_adv};

    occ_d = occ_q;
    if (acc && !pop)
      occ_d = occ_q + 3'd1;
    else if (!acc && pop)
      occ_d = occ_q - 3'd1;

    if (bus.flush) begin
      s1_v_d  = 1'b0;
      s2_v_d  = 1'b0;
      q_cnt_d = 2'd0;
      occ_d   = 3'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q     <= 1'b0;
      s1_tag_q   <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s2_v_q     <= 1'b0;
      s2_tag_q   <= '0;
      s2_p_q     <= '0;
      q_cnt_q    <= 2'd0;
      q_tag_q[0] <= '0;
      q_tag_q[1] <= '0;
      q_dat_q[0] <= '0;
      q_dat_q[1] <= '0;
      occ_q      <= 3'd0;
    end else begin
      s1_v_q   <= s1_v_d;
      s1_tag_q <= s1_tag_d;
      s1_a_q   <= s1_a_d;
      s1_b_q   <= s1_b_d;
      s2_v_q   <= s2_v_d;
      s2_tag_q <= s2_tag_d;
      s2_p_q   <= s2_p_d;
      q_cnt_q  <= q_cnt_d;
      q_tag_q  <= q_tag_d;
      q_dat_q  <= q_dat_d;
      occ_q    <= occ_d;
    end
  end

endmodule

// File: tb/tb_mul_fu.sv
// Scoreboard bench for mul_fu: directed ops, backpressure,
// full-queue push/pop, flush and mid-stream reset.
module tb_mul_fu;

  typedef struct packed {
    logic [3:0]  tag;
    logic [31:0] data;
  } exp_t;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;
  int   n_acc;
  exp_t sb [$];
  exp_t e;

  mul_fu_if #(.TAG_W(4)) bus ();

  mul_fu #(
    .TAG_W(4),
    .DEPTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(
    input bit          v,
    input logic [3:0]  t,
    input logic [15:0] a,
    input logic [15:0] b,
    input logic [31:0] ex,
    input bit          fl,
    input bit          gr,
    input bit          rs
  );
    @(negedge clk);
    rst           = rs;
    bus.in_valid  = v;
    bus.in_tag    = t;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.flush     = fl;
    bus.cdb_grant = gr;
    if (rs || fl) begin
      sb.delete();
    end else if (v && bus.in_ready) begin
      sb.push_back('{tag: t, data: ex});
      n_acc++;
    end
  endtask

  task automatic idle(input bit gr, input bit rs);
    step(1'b0, 4'd0, 16'd0, 16'd0, 32'd0, 1'b0, gr, rs);
  endtask

  // Monitor: a pop is an edge with cdb_req && cdb_grant outside flush/reset.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (bus.cdb_req && bus.cdb_grant && !bus.flush && !rst) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL cdb_unexpected: got tag %h data %h expected none",
                   bus.cdb_tag, bus.cdb_data);
        end else begin
          e = sb.pop_front();
          chk("cdb_tag", 32'(bus.cdb_tag), 32'(e.tag));
          chk("cdb_data", bus.cdb_data, e.data);
        end
      end
    end
  end

  initial begin
    n_chk = 0;
    n_fail = 0;
    n_acc = 0;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_tag = '0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.flush = 1'b0;
    bus.cdb_grant = 1'b0;

    idle(0, 1);
    idle(0, 1);
    idle(1, 0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_occ", 32'(bus.occ), 32'd0);
    chk("rst_cdb_req", 32'(bus.cdb_req), 32'd0);
    chk("rst_cdb_data", bus.cdb_data, 32'd0);
    chk("rst_cdb_tag", 32'(bus.cdb_tag), 32'd0);

    // single op, latency
    step(1, 4'd2, 16'h0003, 16'h0005, 32'h0000000F, 0, 1, 0);
    idle(1, 0);
    chk("single_req_e0", 32'(bus.cdb_req), 32'd0);
    chk("single_occ_e0", 32'(bus.occ), 32'd1);
    idle(1, 0);
    chk("single_req_e1", 32'(bus.cdb_req), 32'd0);
    idle(1, 0);
    chk("single_req_e2", 32'(bus.cdb_req), 32'd1);
    chk("single_data", bus.cdb_data, 32'h0000000F);
    chk("single_tag", 32'(bus.cdb_tag), 32'd2);
    idle(1, 0);
    chk("single_req_drop", 32'(bus.cdb_req), 32'd0);
    chk("single_occ_end", 32'(bus.occ), 32'd0);

    // extremes
    step(1, 4'd3, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 0, 1, 0);
    step(1, 4'd4, 16'h0000, 16'hABCD, 32'h00000000, 0, 1, 0);
    step(1, 4'd5, 16'h8000, 16'h0002, 32'h00010000, 0, 1, 0);
    repeat (5) idle(1, 0);
    chk("ext_occ_end", 32'(bus.occ), 32'd0);

    // backpressure: 6 offers, grant low
    n_acc = 0;
    step(1, 4'd1, 16'h0002, 16'h0003, 32'h00000006, 0, 0, 0);
    step(1, 4'd2, 16'h0100, 16'h0100, 32'h00010000, 0, 0, 0);
    step(1, 4'd3, 16'h1234, 16'h0010, 32'h00012340, 0, 0, 0);
    step(1, 4'd4, 16'h00FF, 16'h00FF, 32'h0000FE01, 0, 0, 0);
    step(1, 4'd5, 16'h7FFF, 16'h0002, 32'h0000FFFE, 0, 0, 0);
    step(1, 4'd6, 16'h0400, 16'h0400, 32'h00100000, 0, 0, 0);
    chk("bp_accepted", 32'(n_acc), 32'd4);
    chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
    chk("bp_occ", 32'(bus.occ), 32'd4);
    idle(0, 0);
    idle(0, 0);
    chk("bp_hold_req", 32'(bus.cdb_req), 32'd1);
    chk("bp_hold_tag", 32'(bus.cdb_tag), 32'd1);
    chk("bp_hold_data", bus.cdb_data, 32'h00000006);
    for (int i = 0; i < 4; i++) begin
      idle(1, 0);
      chk("bp_drain_req", 32'(bus.cdb_req), 32'd1);
    end
    idle(1, 0);
    chk("bp_drained_req", 32'(bus.cdb_req), 32'd0);
    chk("bp_drained_occ", 32'(bus.occ), 32'd0);

    // full queue: simultaneous push and pop
    step(1, 4'd7, 16'h0003, 16'h0007, 32'h00000015, 0, 0, 0);
    step(1, 4'd8, 16'h0010, 16'h0010, 32'h00000100, 0, 0, 0);
    step(1, 4'd9, 16'hFFFF, 16'h0001, 32'h0000FFFF, 0, 0, 0);
    step(1, 4'd10, 16'h1000, 16'h1000, 32'h01000000, 0, 0, 0);
    idle(0, 0);
    chk("fq_occ_full", 32'(bus.occ), 32'd4);
    idle(1, 0);
    step(1, 4'd11, 16'h0005, 16'h0005, 32'h00000019, 0, 0, 0);
    chk("fq_occ_after_pop", 32'(bus.occ), 32'd3);
    idle(0, 0);
    chk("fq_occ_refill", 32'(bus.occ), 32'd4);
    chk("fq_head_tag", 32'(bus.cdb_tag), 32'd8);
    repeat (6) idle(1, 0);
    chk("fq_occ_end", 32'(bus.occ), 32'd0);

    // flush with 3 in flight and an offer in the flush cycle
    step(1, 4'd12, 16'h0001, 16'h0001, 32'h00000001, 0, 0, 0);
    step(1, 4'd13, 16'h0002, 16'h0002, 32'h00000004, 0, 0, 0);
    step(1, 4'd14, 16'h0003, 16'h0003, 32'h00000009, 0, 0, 0);
    step(1, 4'd15, 16'h0004, 16'h0004, 32'h00000010, 1, 0, 0);
    chk("fl_occ_pre", 32'(bus.occ), 32'd3);
    idle(1, 0);
    chk("fl_occ", 32'(bus.occ), 32'd0);
    chk("fl_req", 32'(bus.cdb_req), 32'd0);
    repeat (4) idle(1, 0);
    chk("fl_req_late", 32'(bus.cdb_req), 32'd0);

    // reset mid-stream with grant high
    step(1, 4'd1, 16'h0011, 16'h0011, 32'h00000121, 0, 1, 0);
    step(1, 4'd2, 16'h0100, 16'h0003, 32'h00000300, 0, 1, 0);
    step(1, 4'd3, 16'h00FF, 16'h0101, 32'h0000FFFF, 0, 1, 0);
    idle(1, 1);
    chk("rm_occ_pre", 32'(bus.occ), 32'd3);
    chk("rm_req_pre", 32'(bus.cdb_req), 32'd1);
    idle(1, 0);
    chk("rm_occ", 32'(bus.occ), 32'd0);
    chk("rm_req", 32'(bus.cdb_req), 32'd0);
    chk("rm_data", bus.cdb_data, 32'd0);
    chk("rm_in_ready", 32'(bus.in_ready), 32'd1);
    step(1, 4'd5, 16'h0007, 16'h0009, 32'h0000003F, 0, 1, 0);
    repeat (5) idle(1, 0);
    chk("rm_occ_end", 32'(bus.occ), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_fu.md
MUL_FU -- requirements
Module: mul_fu

Interface
REQ-001 The block SHALL have parameter TAG_W, default 4, giving the reservation-station tag width.
REQ-002 The block SHALL have parameter DEPTH, fixed at 4, giving the maximum number of in-flight operations: two pipeline registers plus a 2-entry result queue.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit: issue offers an operation.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the unit can accept an operation this cycle.
REQ-007 The block SHALL have port in_tag, input, TAG_W bits: destination tag of the operation.
REQ-008 The block SHALL have port in_a, input, 16 bits: unsigned multiplicand.
REQ-009 The block SHALL have port in_b, input, 16 bits: unsigned multiplier.
REQ-010 The block SHALL have port flush, input, 1 bit: discard all in-flight work.
REQ-011 The block SHALL have port cdb_req, output, 1 bit: a result is ready for the common data bus.
REQ-012 The block SHALL have port cdb_grant, input, 1 bit: the arbiter accepts the presented result this cycle.
REQ-013 The block SHALL have port cdb_tag, output, TAG_W bits: tag of the presented result.
REQ-014 The block SHALL have port cdb_data, output, 32 bits: the presented product.
REQ-015 The block SHALL have port occ, output, 3 bits: current in-flight count, 0..4.

Function
REQ-016 The block SHALL accept an operation on a rising edge where in_valid && in_ready && !flush && !rst hold.
REQ-017 in_ready SHALL be (occ < 4), driven from registered state only, with no combinational path from in_valid, cdb_grant or flush.
REQ-018 Stage S1 SHALL register in_tag, in_a and in_b on acceptance.
REQ-019 Stage S2 SHALL register tag and the full 32-bit unsigned product A*B computed combinationally from S1 by the 16x16 Wallace multiplier; no truncation and no sign extension are permitted.
REQ-020 S2 SHALL advance into the result queue when the queue has fewer than 2 entries, or when it holds 2 entries and a pop occurs in the same cycle; otherwise S2 SHALL hold.
REQ-021 S1 SHALL advance to S2 when S2 is empty or S2 advances in the same cycle; otherwise S1 SHALL hold.
REQ-022 Unstalled latency SHALL be: accept at edge E0, S2 valid after E0+1, queue entry written at E0+2, and cdb_req high during the cycle following E0+2.
REQ-023 cdb_req SHALL equal queue-not-empty; cdb_tag and cdb_data SHALL present the queue head and SHALL remain stable while cdb_req is high and cdb_grant is low.
REQ-024 A pop SHALL occur on an edge where cdb_req && cdb_grant; cdb_grant while cdb_req is low SHALL be ignored.
REQ-025 Results SHALL leave in acceptance order; no reordering and no drops are permitted.
REQ-026 occ SHALL increment on acceptance, decrement on pop, and stay unchanged on a simultaneous accept and pop; it SHALL never exceed 4 or underflow.
REQ-027 Simultaneous push and pop on a full queue SHALL be legal, leaving 2 entries with the head replaced correctly.
REQ-028 flush SHALL, at the next edge, invalidate S1, S2 and all queue entries and set occ to 0; an offer present in the flush cycle is not accepted and a grant in the flush cycle is irrelevant.
REQ-029 Data registers SHALL be don't-care when invalid; only the valid bits and occ are architecturally visible.

Reset
REQ-030 On rst high at a rising edge, all valid bits SHALL clear and occ=0, giving cdb_req=0 and in_ready=1 in the next cycle; cdb_tag and cdb_data SHALL reset to 0.
REQ-031 rst asserted mid-operation SHALL discard all in-flight work, identical to flush, and SHALL take priority over flush, acceptance and pop.

Verification
REQ-032 The bench SHALL cover single op: a=0x0003, b=0x0005, tag=2, grant held high -> cdb_req rises 2 edges after acceptance with cdb_data=0x0000000F and cdb_tag=2, then drops after 1 cycle.
REQ-033 The bench SHALL cover extremes: 0xFFFF*0xFFFF -> 0xFFFE0001; 0x0000*0xABCD -> 0x00000000; 0x8000*0x0002 -> 0x00010000.
REQ-034 The bench SHALL cover backpressure: grant held low while offering 6 back-to-back ops -> exactly 4 accepted, in_ready=0 with occ=4; on releasing grant, 4 results emerge in tag order, one per cycle.
REQ-035 The bench SHALL cover a full-queue simultaneous accept and pop: occ=4 -> grant for 1 cycle, then offer next cycle -> occ goes 3 then 4, and order is preserved.
REQ-036 The bench SHALL cover flush: 3 ops in flight plus an offer in the flush cycle -> next cycle occ=0 and cdb_req=0; none of the 4 tags ever appears on the CDB.
REQ-037 The bench SHALL cover reset mid-stream: rst pulsed with occ=3 and grant high -> no pop is counted, occ=0, cdb_data=0, and a subsequent op completes normally.
